// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and protocol byte constants for uart_boot_loader.
package loader_pkg;
   typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, CSUM, RESP, GO} state_e;
   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_NAK  = 8'h15;
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte idle watchdog; reloads on every rx transfer, expires after TIMEOUT_CYC idle cycles.
module loader_timeout #(
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run_i,
   input  logic kick_i,
   output logic expired_o
);
   localparam int W = $clog2(TIMEOUT_CYC + 1);
   logic [W-1:0] timer_q, timer_d;
   assign expired_o = run_i && !kick_i && timer_q == '0;
   assign timer_d = (!run_i || kick_i) ? W'(TIMEOUT_CYC - 1) : timer_q - W'(1);
   always_ff @(posedge clk) begin
      if (!reset_n) timer_q <= '0;
      else timer_q <= timer_d;
   end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: UART byte-stream boot loader ('L' load / 'G' go frames) with a word-write memory port.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte on 'L' frames.
module uart_boot_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [7:0]        rx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [7:0]        tx_data,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   output logic              go,
   output logic [ADDR_W-1:0] go_addr
);
`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif
   state_e state_q, state_d, after_data;
   logic rx_ready_q, rx_ready_d, is_go_q, is_go_d;
   logic [1:0] idx_q, idx_d, lane;
   logic [31:0] sh_q, sh_d, wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0] wstrb_q, wstrb_d;
   logic [7:0] csum_q, csum_d, rsp_q, rsp_d;
   logic rx_fire, timed, expired;
   assign rx_fire    = rx_valid && rx_ready_q;
   assign timed      = state_q inside {ADDR, LEN, DATA, CSUM};
   assign lane       = addr_q[1:0];
   assign after_data = CSUM_EN ? CSUM : RESP;
   assign rx_ready   = rx_ready_q;
   assign tx_valid   = state_q == RESP;
   assign tx_data    = rsp_q;
   assign mem_valid  = state_q == WRITE;
   assign mem_addr   = maddr_q;
   assign mem_wdata  = wdata_q;
   assign mem_wstrb  = wstrb_q;
   assign go         = state_q == GO;
   assign go_addr    = addr_q;
   loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk      (clk),
      .reset_n  (reset_n),
      .run_i    (timed),
      .kick_i   (rx_fire),
      .expired_o(expired)
   );
   always_comb begin
      state_d = state_q;
      is_go_d = is_go_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      addr_d  = addr_q;
      maddr_d = maddr_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      csum_d  = csum_q;
      rsp_d   = rsp_q;
      if (expired) begin
         state_d = IDLE;
         wdata_d = '0;
         wstrb_d = '0;
      end else begin
         case (state_q)
            IDLE: if (rx_fire && (rx_data == CMD_LOAD || rx_data == CMD_GO)) begin
               state_d = ADDR;
               is_go_d = rx_data == CMD_GO;
               idx_d   = '0;
               wdata_d = '0;
               wstrb_d = '0;
               csum_d  = '0;
               rsp_d   = RSP_ACK;
            end
            ADDR: if (rx_fire) begin
               sh_d  = {rx_data, sh_q[31:8]};
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  addr_d  = ADDR_W'(sh_d);
                  state_d = is_go_q ? GO : LEN;
               end
            end
            LEN: if (rx_fire) begin
               sh_d  = {rx_data, sh_q[31:8]};
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd1) begin
                  cnt_d   = sh_d[31:16];
                  state_d = cnt_d == '0 ? after_data : DATA;
               end
            end
            DATA: if (rx_fire) begin
               wdata_d[8*lane +: 8] = rx_data;
               wstrb_d[lane]        = 1'b1;
               maddr_d = {addr_q[ADDR_W-1:2], 2'b00};
               addr_d  = addr_q + ADDR_W'(1);
               cnt_d   = cnt_q - 16'd1;
               csum_d  = csum_q + rx_data;
               // flush on a filled word or on the final byte of the frame
               if (lane == 2'd3 || cnt_q == 16'd1) state_d = WRITE;
            end
            WRITE: if (mem_ready) begin
               wdata_d = '0;
               wstrb_d = '0;
               state_d = cnt_q == '0 ? after_data : DATA;
            end
            CSUM: if (rx_fire) begin
               rsp_d   = rx_data == csum_q ? RSP_ACK : RSP_NAK;
               state_d = RESP;
            end
            RESP: if (tx_ready) state_d = IDLE;
            GO: state_d = RESP;
            default: state_d = IDLE;
         endcase
      end
      rx_ready_d = state_d inside {IDLE, ADDR, LEN, DATA, CSUM};
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rx_ready_q <= 1'b0;
         is_go_q    <= 1'b0;
         idx_q      <= '0;
         sh_q       <= '0;
         addr_q     <= '0;
         maddr_q    <= '0;
         cnt_q      <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         csum_q     <= '0;
         rsp_q      <= '0;
      end else begin
         state_q    <= state_d;
         rx_ready_q <= rx_ready_d;
         is_go_q    <= is_go_d;
         idx_q      <= idx_d;
         sh_q       <= sh_d;
         addr_q     <= addr_d;
         maddr_q    <= maddr_d;
         cnt_q      <= cnt_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         csum_q     <= csum_d;
         rsp_q      <= rsp_d;
      end
   end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames against a scoreboard of expected word writes, responses and go pulses.
module tb_uart_boot_loader;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif
   typedef logic [7:0] bq_t[$];
   typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} wr_t;
   logic clk = 1'b0, reset_n = 1'b0;
   logic rx_valid = 1'b0, rx_ready, tx_valid, tx_ready = 1'b0, mem_valid, mem_ready = 1'b0, go;
   logic [7:0] rx_data = '0, tx_data;
   logic [31:0] mem_addr, mem_wdata, go_addr;
   logic [3:0] mem_wstrb;
   int tests = 0, fails = 0, mem_stall = 0, tx_stall = 0, mv_cnt = 0, tv_cnt = 0;
   wr_t exp_w[$], obs_w[$];
   logic [7:0] exp_tx[$], obs_tx[$];
   logic [31:0] exp_go[$], obs_go[$];
   logic prev_mv = 1'b0, prev_mr = 1'b0, prev_go = 1'b0;
   wr_t prev_w;

   uart_boot_loader #(.ADDR_W(32), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .reset_n(reset_n),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .go(go), .go_addr(go_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // memory and tx sinks: ready after the configured number of stall cycles
   initial forever begin
      @(posedge clk); #1;
      mv_cnt = mem_valid ? mv_cnt + 1 : 0;
      tv_cnt = tx_valid ? tv_cnt + 1 : 0;
      mem_ready = mem_valid && mv_cnt > mem_stall;
      tx_ready  = tx_valid && tv_cnt > tx_stall;
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_mv = 1'b0;
         prev_go = 1'b0;
      end else begin
         if (mem_valid && prev_mv && !prev_mr)
            check("mem_hold", {mem_addr, mem_wdata, mem_wstrb}, prev_w);
         if (mem_valid || tx_valid) check("rx_ready_low", rx_ready, 1'b0);
         if (go) begin
            check("go_width", prev_go, 1'b0);
            obs_go.push_back(go_addr);
            if (exp_go.size() == 0) begin
               tests++; fails++;
               $display("FAIL go_unexpected: go_addr=%h with no go required", go_addr);
            end else check("go_addr", go_addr, exp_go.pop_front());
         end
         if (mem_valid && mem_ready) begin
            obs_w.push_back({mem_addr, mem_wdata, mem_wstrb});
            if (exp_w.size() == 0) begin
               tests++; fails++;
               $display("FAIL mem_unexpected: addr=%h wdata=%h wstrb=%b with no write required", mem_addr, mem_wdata, mem_wstrb);
            end else check("mem_write", {mem_addr, mem_wdata, mem_wstrb}, exp_w.pop_front());
         end
         if (tx_valid && tx_ready) begin
            obs_tx.push_back(tx_data);
            if (exp_tx.size() == 0) begin
               tests++; fails++;
               $display("FAIL tx_unexpected: tx_data=%h with no response required", tx_data);
            end else check("tx_data", tx_data, exp_tx.pop_front());
         end
         prev_mv = mem_valid;
         prev_mr = mem_ready;
         prev_w  = {mem_addr, mem_wdata, mem_wstrb};
         prev_go = go;
      end
   end

   task automatic send(input logic [7:0] b);
      bit ok = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      for (int n = 0; n < 2000 && !ok; n++) begin
         @(negedge clk);
         ok = rx_ready;
      end
      check("rx_accept", ok, 1'b1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   // one memory word per distinct word address touched, in byte order
   task automatic model_load(input logic [31:0] a, input bq_t d);
      wr_t w = '0;
      bit have = 1'b0;
      for (int i = 0; i < d.size(); i++) begin
         logic [31:0] ba = a + 32'(i);
         if (have && w.a != {ba[31:2], 2'b00}) begin
            exp_w.push_back(w);
            have = 1'b0;
         end
         if (!have) begin
            w = '0;
            w.a = {ba[31:2], 2'b00};
            have = 1'b1;
         end
         w.d[8*ba[1:0] +: 8] = d[i];
         w.s[ba[1:0]] = 1'b1;
      end
      if (have) exp_w.push_back(w);
   endtask

   task automatic send_load(input logic [31:0] a, input bq_t d, input bit good);
      logic [7:0] sum = '0;
      logic [15:0] len = 16'(d.size());
      foreach (d[i]) sum = sum + d[i];
      model_load(a, d);
      exp_tx.push_back((CSUM_EN && !good) ? 8'h15 : 8'h06);
      send(8'h4C);
      for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
      send(len[7:0]);
      send(len[15:8]);
      foreach (d[i]) send(d[i]);
      if (CSUM_EN) send(good ? sum : sum ^ 8'h5A);
   endtask

   task automatic send_go(input logic [31:0] a);
      exp_go.push_back(a);
      exp_tx.push_back(8'h06);
      send(8'h47);
      for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 500 && exp_w.size() + exp_tx.size() + exp_go.size() != 0; n++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("drain", exp_w.size() + exp_tx.size() + exp_go.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rx_ready"}, rx_ready, 1'b0);
      check({tag, "_tx_valid"}, tx_valid, 1'b0);
      check({tag, "_mem_valid"}, mem_valid, 1'b0);
      check({tag, "_go"}, go, 1'b0);
      check({tag, "_mem_addr"}, mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      check({tag, "_mem_wstrb"}, mem_wstrb, 4'h0);
      check({tag, "_go_addr"}, go_addr, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bq_t d;
      int base;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      check("reset_tx_data", tx_data, 8'h00);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // aligned 4-byte load
      base = obs_w.size();
      d = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_load(32'h0000_1000, d, 1'b1);
      wait_drain();
      check("l1_addr", obs_w[base].a, 32'h0000_1000);
      check("l1_wdata", obs_w[base].d, 32'h4433_2211);
      check("l1_wstrb", obs_w[base].s, 4'hF);
      check("l1_ack", obs_tx[obs_tx.size()-1], 8'h06);

      // unaligned load with a stalled memory
      mem_stall = 5;
      base = obs_w.size();
      d = '{8'hAA, 8'hBB, 8'hCC};
      send_load(32'h0000_1003, d, 1'b1);
      wait_drain();
      mem_stall = 0;
      check("l2_count", obs_w.size() - base, 2);
      check("l2_w0", obs_w[base], {32'h0000_1000, 32'hAA00_0000, 4'b1000});
      check("l2_w1", obs_w[base+1], {32'h0000_1004, 32'h0000_CCBB, 4'b0011});

      // go frame
      base = obs_go.size();
      send_go(32'h8000_0000);
      wait_drain();
      check("g1_addr", obs_go[base], 32'h8000_0000);

      // zero-length load, then a load with a corrupted checksum
      base = obs_w.size();
      d = {};
      send_load(32'h0000_2000, d, 1'b1);
      wait_drain();
      check("l0_nowrite", obs_w.size() - base, 0);
      check("l0_ack", obs_tx[obs_tx.size()-1], 8'h06);
      d = '{8'h01, 8'h02};
      send_load(32'h0000_1001, d, 1'b0);
      wait_drain();
      check("lbad_w", obs_w[obs_w.size()-1], {32'h0000_1000, 32'h0002_0100, 4'b0110});

      // address wrap at the top of the space, with a slow tx sink
      tx_stall = 3;
      base = obs_w.size();
      d = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_load(32'hFFFF_FFFE, d, 1'b1);
      wait_drain();
      tx_stall = 0;
      check("wrap_w0", obs_w[base], {32'hFFFF_FFFC, 32'h0201_0000, 4'b1100});
      check("wrap_w1", obs_w[base+1], {32'h0000_0000, 32'h0000_0403, 4'b0011});

      // longer frame spanning three words
      base = obs_w.size();
      d = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
      send_load(32'h0000_3002, d, 1'b1);
      wait_drain();
      check("l9_w2", obs_w[base+2], {32'h0000_3008, 32'h0090_8070, 4'b0111});

      // gap shorter than the timeout keeps the frame alive
      exp_go.push_back(32'h4000_0000);
      exp_tx.push_back(8'h06);
      send(8'h47); send(8'h00); send(8'h00);
      repeat (90) @(posedge clk);
      #1;
      send(8'h00); send(8'h40);
      wait_drain();

      // abandoned frame: silence beyond the timeout, then stray byte, then a fresh go
      send(8'h4C); send(8'h00); send(8'h10);
      repeat (110) @(posedge clk);
      #1;
      send(8'h00);
      send_go(32'h0000_0123);
      wait_drain();

      // reset in the middle of data with tx blocked
      tx_stall = 1000;
      send(8'h4C);
      send(8'h02); send(8'h40); send(8'h00); send(8'h00);
      send(8'h04); send(8'h00);
      send(8'h11); send(8'h22);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("midreset");
      @(posedge clk); #1;
      tx_stall = 0;
      d = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
      send_load(32'h0000_4000, d, 1'b1);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter ADDR_W, default 32, width of the memory write address and of go_addr.
REQ-002 Parameter TIMEOUT_CYC, default 50_000_000, idle cycles between bytes of a frame before the frame is abandoned.
REQ-003 Port clk input 1: sole clock; all logic is on its rising edge.
REQ-004 Port reset_n input 1: reset, synchronous and active-low.
REQ-005 Ports rx_valid input 1, rx_ready output 1, rx_data input 8: byte stream from axi_uart. A byte transfers when valid and ready are both high.
REQ-006 Ports tx_valid output 1, tx_ready input 1, tx_data output 8: response byte stream to axi_uart. A byte transfers when valid and ready are both high.
REQ-007 Ports mem_valid output 1, mem_ready input 1, mem_addr output ADDR_W, mem_wdata output 32, mem_wstrb output 4: word write port. A write completes when valid and ready are both high.
REQ-008 Ports go output 1 and go_addr output ADDR_W: one-cycle start pulse with the entry address.

Function
REQ-009 Frames: 'L' (0x4C) + addr[4] LE + len[2] LE + len data bytes; 'G' (0x47) + addr[4] LE.
REQ-010 Any other byte received in IDLE is consumed and discarded; state stays IDLE.
REQ-011 FSM states: IDLE, ADDR, LEN, DATA, WRITE, CSUM, RESP, GO.
- IDLE: 'L' -> ADDR(load); 'G' -> ADDR(go).
- ADDR: after 4 bytes, load -> LEN, go -> GO.
- LEN: after 2 bytes -> DATA, or -> CSUM/RESP if len=0.
REQ-012 rx_ready is high only in IDLE, ADDR, LEN, DATA and CSUM, and is low while mem_valid or tx_valid is high.
REQ-013 Each data byte at current address A goes to lane A[1:0]: wdata[8*A[1:0]+:8], with strobe bit A[1:0] set. A then increments by 1.
REQ-014 Word write (DATA -> WRITE): entered after a byte lands in lane 3 or after the last byte. mem_addr = {A[ADDR_W-1:2],2'b00} of the word being written.
REQ-015 The word write holds mem_valid, addr, wdata and wstrb stable until mem_ready. Strobes and wdata are then cleared and the FSM returns to DATA, or moves on to CSUM/RESP once the count is exhausted.
REQ-016 Unaligned start and end produce partial strobes: start 0x1001 with len 2 gives one write, addr 0x1000, wstrb 4'b0110.
REQ-017 Byte count is 16 bits and decrements per byte; 0xFFFF is legal. The address wraps modulo 2^ADDR_W.
REQ-018 RESP drives tx_valid with 0x06 (ACK), or 0x15 (NAK, REQ-023), until tx_ready, then -> IDLE.
REQ-019 GO: go=1 for exactly one cycle with go_addr = received addr; tx sends ACK; then -> IDLE.
REQ-020 Timeout: in ADDR, LEN, DATA or CSUM, TIMEOUT_CYC cycles with no rx transfer -> IDLE. No response is sent and no partial-word write is issued.
REQ-021 Latency: a byte accepted in cycle N is reflected in state or registers at N+1; mem_valid asserts no later than 1 cycle after the completing byte is accepted.

Reset
REQ-022 While reset_n=0 at a clock edge:
- state=IDLE;
- rx_ready, tx_valid, mem_valid, go = 0;
- mem_addr, mem_wdata, mem_wstrb, go_addr, count, timer, checksum = 0.
Reset mid-frame or mid-write abandons the frame immediately.

Configuration
REQ-023 Macro LOADER_CHECKSUM_EN defined:
- after the data of an 'L' frame, one checksum byte (CSUM state) is required;
- ACK if it equals the 8-bit modulo sum of the data bytes, else NAK.
Memory writes are never withheld. Undefined: no CSUM state, 'L' always answers ACK.

Structure
REQ-024 Package loader_pkg holds the state enum and the constants CMD_LOAD=0x4C, CMD_GO=0x47, RSP_ACK=0x06, RSP_NAK=0x15.
REQ-025 Sub-module loader_timeout holds the TIMEOUT_CYC down-counter, reloaded on every rx transfer. All other logic stays in one module.

Verification
REQ-026 'L',00 10 00 00,04 00,11 22 33 44 (plus csum 0xAA if enabled) -> one write addr 0x1000, wdata 0x44332211, wstrb 0xF; tx 0x06.
REQ-027 'L' at addr 0x1003, len 3, bytes AA BB CC, mem_ready held low 5 cycles -> writes:
- 0x1000 wstrb 1000 wdata[31:24]=AA;
- 0x1004 wstrb 0011 = 0xCCBB;
rx_ready stays low during the stall.
REQ-028 'G',00 00 00 80 -> go pulse of width 1 with go_addr 0x80000000; tx 0x06.
REQ-029 With LOADER_CHECKSUM_EN and a bad checksum byte -> the write still occurs; tx 0x15. With len 0 -> no write; ACK.
REQ-030 'L' followed by 2 address bytes then silence for TIMEOUT_CYC (set to 100) -> back to IDLE with no tx. A subsequent 0x00 byte is ignored, then a valid 'G' frame is answered.
REQ-031 reset_n low for 1 cycle mid-DATA with tx_ready low -> all outputs are 0 the next cycle. A fresh frame then completes correctly.
